// File: rtl/div_meter_pkg.sv
// div_meter_pkg: shared state type, default widths and helpers for div_clk_meter
package div_meter_pkg;
  typedef enum logic {IDLE, MEAS} state_t;
  localparam int CW_DEF = 16;
  localparam int TOL_DEF = 1;
  localparam int MW = 32;
  // Widest supported counter; callers truncate the result back to CW+1 bits
  function automatic logic [MW:0] abs_diff(input logic [MW-1:0] a, input logic [MW-1:0] b);
    return a >= b ? {1'b0, a - b} : {1'b0, b - a};
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer with registered previous value for rising-edge detect
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sr;
  logic s_q;
  always_ff @(posedge clkin) begin
    if (rst) begin
      sr  <= '0;
      s_q <= 1'b0;
    end else begin
      sr  <= {sr[SYNC_STAGES-2:0], sig_in};
      s_q <= sr[SYNC_STAGES-1];
    end
  end
  assign s = sr[SYNC_STAGES-1];
  assign rise = s & ~s_q;
endmodule

// File: rtl/div_clk_meter.sv
// div_clk_meter: measures period/high time of a divided clock and flags error, lock and stuck
module div_clk_meter import div_meter_pkg::*; #(
  parameter int CW = CW_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TOL = TOL_DEF,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          sig_in,
  input  logic [CW-1:0] exp_period,
  input  logic [CW-1:0] exp_high,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          meas_valid,
  output logic          err,
  output logic          locked,
  output logic          stuck
);
  localparam int RW = $clog2(LOCK_CNT + 1);
  state_t state;
  logic s, rise, bad;
  logic [CW-1:0] per_cnt, hi_cnt;
  logic [CW:0] dp, dh;
  logic [RW-1:0] run, run_nxt;
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clkin (clkin),
    .rst   (rst),
    .sig_in(sig_in),
    .s     (s),
    .rise  (rise)
  );
  always_comb begin
    dp = (CW+1)'(abs_diff(MW'(per_cnt), MW'(exp_period)));
    dh = (CW+1)'(abs_diff(MW'(hi_cnt), MW'(exp_high)));
    bad = dp > (CW+1)'(TOL) || dh > (CW+1)'(TOL);
    run_nxt = run == RW'(LOCK_CNT) ? run : run + 1'b1;
  end
  // A rise in MEAS closes the current period; the timeout path only runs when no rise is present
  always_ff @(posedge clkin) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      locked     <= 1'b0;
      stuck      <= 1'b0;
      run        <= '0;
    end else begin
      meas_valid <= 1'b0;
      err        <= 1'b0;
      stuck      <= 1'b0;
      if (state == IDLE) begin
        if (rise) begin
          per_cnt <= CW'(1);
          hi_cnt  <= CW'(1);
          state   <= MEAS;
        end
      end else if (rise) begin
        period     <= per_cnt;
        high_time  <= hi_cnt;
        meas_valid <= 1'b1;
        err        <= bad;
        per_cnt    <= CW'(1);
        hi_cnt     <= CW'(1);
        run        <= bad ? '0 : run_nxt;
        locked     <= !bad && run_nxt == RW'(LOCK_CNT);
      end else if (per_cnt == CW'(TIMEOUT)) begin
        stuck   <= 1'b1;
        locked  <= 1'b0;
        run     <= '0;
        per_cnt <= '0;
        hi_cnt  <= '0;
        state   <= IDLE;
      end else begin
        per_cnt <= per_cnt == '1 ? per_cnt : per_cnt + 1'b1;
        hi_cnt  <= (s && hi_cnt != '1) ? hi_cnt + 1'b1 : hi_cnt;
      end
    end
  end
endmodule

// File: tb/tb_div_clk_meter.sv
// tb_div_clk_meter: directed checks of measurement, tolerance, lock, timeout, reset and odd-divider sampling
module tb_div_clk_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv = 1'b0;
  logic div_en = 1'b0;
  logic sig_in;
  logic [15:0] exp_period = 16'd5;
  logic [15:0] exp_high = 16'd3;
  logic [15:0] period, high_time;
  logic meas_valid, err, locked, stuck;
  logic [2:0] dcnt = '0;
  logic q_p = 1'b0;
  logic q_n = 1'b0;
  int cyc = 0;
  int rise_cyc = 0;
  int meas_cyc = 0;
  int stuck_cyc = 0;
  int nstuck = 0;
  int qp[$], qh[$], qe[$], ql[$];
  int checks = 0;
  int failures = 0;
  int b, ns;

  div_clk_meter #(.CW(16), .SYNC_STAGES(2), .TOL(1), .LOCK_CNT(4), .TIMEOUT(64)) dut (
    .clkin     (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .exp_period(exp_period),
    .exp_high  (exp_high),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .err       (err),
    .locked    (locked),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Odd divide-by-5 with negedge path: 2.5 clkin cycles high per period
  always @(posedge clk) begin
    dcnt <= dcnt == 3'd4 ? 3'd0 : dcnt + 3'd1;
    q_p <= dcnt < 3'd2;
  end
  always @(negedge clk) q_n <= q_p;
  assign sig_in = div_en ? (q_p | q_n) : drv;

  always @(negedge clk) begin
    if (meas_valid) begin
      qp.push_back(int'(period));
      qh.push_back(int'(high_time));
      qe.push_back(int'(err));
      ql.push_back(int'(locked));
      meas_cyc = cyc;
    end
    if (stuck) begin
      nstuck++;
      stuck_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    rise_cyc = cyc;
    drv = 1'b1;
    repeat (hi) @(negedge clk);
    drv = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_period", int'(period), 0);
    check("rst_high", int'(high_time), 0);
    check("rst_valid", int'(meas_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_stuck", int'(stuck), 0);
    rst = 1'b0;
    @(negedge clk);
    // Ideal 11100 stream
    b = qp.size();
    pulse(3, 2);
    check("t1_first_rise", qp.size() - b, 0);
    pulse(3, 2);
    check("t1_count2", qp.size() - b, 1);
    check("t1_latency", meas_cyc - rise_cyc, 3);
    repeat (3) pulse(3, 2);
    check("t1_count5", qp.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_period", qp[b+i], 5);
      check("t1_high", qh[b+i], 3);
      check("t1_err", qe[b+i], 0);
    end
    check("t1_lock3", ql[b+2], 0);
    check("t1_lock4", ql[b+3], 1);
    // Tolerance boundaries
    b = qp.size();
    pulse(3, 3);
    pulse(3, 4);
    pulse(4, 1);
    pulse(5, 1);
    pulse(3, 2);
    check("t2_count", qp.size() - b, 5);
    check("t2_p6", qp[b+1], 6);
    check("t2_p6_err", qe[b+1], 0);
    check("t2_p6_lock", ql[b+1], 1);
    check("t2_p7", qp[b+2], 7);
    check("t2_p7_err", qe[b+2], 1);
    check("t2_p7_lock", ql[b+2], 0);
    check("t2_h4", qh[b+3], 4);
    check("t2_h4_err", qe[b+3], 0);
    check("t2_h5", qh[b+4], 5);
    check("t2_h5_err", qe[b+4], 1);
    // Timeout after lock
    repeat (4) pulse(3, 2);
    check("t3_locked", int'(locked), 1);
    ns = nstuck;
    repeat (90) @(negedge clk);
    check("t3_stuck_n", nstuck - ns, 1);
    check("t3_stuck_time", stuck_cyc - rise_cyc, 67);
    check("t3_unlock", int'(locked), 0);
    check("t3_hold_period", int'(period), 5);
    check("t3_hold_high", int'(high_time), 3);
    b = qp.size();
    pulse(3, 2);
    check("t3_resume_first", qp.size() - b, 0);
    repeat (4) pulse(3, 2);
    check("t3_resume_count", qp.size() - b, 4);
    check("t3_resume_p", qp[b], 5);
    check("t3_relock3", ql[b+2], 0);
    check("t3_relock4", ql[b+3], 1);
    // Reset in the low phase while locked
    drv = 1'b1;
    repeat (3) @(negedge clk);
    drv = 1'b0;
    @(negedge clk);
    check("t4_pre_locked", int'(locked), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_period", int'(period), 0);
    check("t4_high", int'(high_time), 0);
    check("t4_locked", int'(locked), 0);
    check("t4_valid", int'(meas_valid), 0);
    @(negedge clk);
    b = qp.size();
    pulse(3, 2);
    check("t4_first", qp.size() - b, 0);
    pulse(3, 2);
    check("t4_second", qp.size() - b, 1);
    check("t4_p", qp[b], 5);
    check("t4_h", qh[b], 3);
    // Glitch in a locked stream
    repeat (4) pulse(3, 2);
    check("t5_locked", int'(locked), 1);
    b = qp.size();
    pulse(1, 1);
    repeat (5) pulse(3, 2);
    check("t5_count", qp.size() - b, 6);
    check("t5_glitch_p", qp[b+1], 2);
    check("t5_glitch_err", qe[b+1], 1);
    check("t5_glitch_lock", ql[b+1], 0);
    check("t5_clean_err", qe[b+2], 0);
    check("t5_relock3", ql[b+4], 0);
    check("t5_relock4", ql[b+5], 1);
    // Free-running odd divider
    div_en = 1'b1;
    b = qp.size();
    for (int i = 0; i < 800 && qp.size() - b < 101; i++) @(negedge clk);
    check("t6_count", int'(qp.size() - b >= 101), 1);
    if (qp.size() - b >= 101) begin
      check("t6_hi_range", int'(qh[b+1] == 2 || qh[b+1] == 3), 1);
      for (int i = 1; i <= 100; i++) begin
        check("t6_period", qp[b+i], 5);
        check("t6_high_const", qh[b+i], qh[b+1]);
        check("t6_err", qe[b+i], 0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
